// File: rtl/phase_stage_sequencer.sv
// Multicycle stage sequencer driven by the one-hot five-phase bus.
// Issues registered one-cycle stage strobes, retries MEM on later rotations, counts retires.
module phase_stage_sequencer #(
  parameter int CNT_W   = 16,
  parameter int STALL_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [4:0]         Phases,
  input  logic               MemReady,
  input  logic               Halt,
  output logic               IfEn,
  output logic               IdEn,
  output logic               ExEn,
  output logic               MemEn,
  output logic               WbEn,
  output logic [CNT_W-1:0]   InstrCount,
  output logic [STALL_W-1:0] StallCount,
  output logic               PhaseErr,
  output logic               Halted
);

  typedef enum logic [1:0] {SYNC, RUN, MEMWAIT, HALTED} state_t;

  state_t     state;
  logic [2:0] stg;
  logic       prev_valid;
  logic [2:0] prev_idx;
  logic [4:0] stb;

  logic [2:0] idx;
  logic [2:0] succ;
  logic       legal;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 5; i++)
      if (Phases[i]) idx = 3'(i);
    succ  = (prev_idx == 3'd4) ? 3'd0 : prev_idx + 3'd1;
    // The first one-hot value after an invalidation is accepted without a successor check.
    legal = $onehot(Phases) && (!prev_valid || idx == succ);
  end

  assign {WbEn, MemEn, ExEn, IdEn, IfEn} = stb;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= SYNC;
      stg        <= 3'd0;
      prev_valid <= 1'b0;
      prev_idx   <= 3'd0;
      stb        <= '0;
      InstrCount <= '0;
      StallCount <= '0;
      PhaseErr   <= 1'b0;
      Halted     <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch reads
      // the pre-edge values; the default clear below is what makes strobes one cycle wide.
      stb <= '0;
      if (state != HALTED) begin
        if (!legal) begin
          PhaseErr   <= 1'b1;
          state      <= SYNC;
          prev_valid <= 1'b0;
        end else begin
          prev_valid <= 1'b1;
          prev_idx   <= idx;
          unique case (state)
            SYNC: begin
              if (idx == 3'd0) begin
                stb   <= 5'b00001;
                stg   <= 3'd1;
                state <= RUN;
              end
            end
            RUN: begin
              if (idx == stg) begin
                if (stg == 3'd3 && !MemReady) begin
                  if (StallCount != '1) StallCount <= StallCount + 1'b1;
                  state <= MEMWAIT;
                end else begin
                  stb <= 5'b00001 << stg;
                  if (stg == 3'd4) begin
                    InstrCount <= InstrCount + 1'b1;
                    stg        <= 3'd0;
                    if (Halt) begin
                      state  <= HALTED;
                      Halted <= 1'b1;
                    end
                  end else begin
                    stg <= stg + 3'd1;
                  end
                end
              end
            end
            MEMWAIT: begin
              // Halt is not looked at here; only the WB sample can stop the sequencer.
              if (idx == 3'd3) begin
                if (MemReady) begin
                  stb   <= 5'b01000;
                  stg   <= 3'd4;
                  state <= RUN;
                end else if (StallCount != '1) begin
                  StallCount <= StallCount + 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_stage_sequencer.sv
// Directed bench for phase_stage_sequencer: a behavioural model fills a scoreboard
// as each cycle is driven; the entry is popped and compared once the DUT has registered it.
module tb_phase_stage_sequencer;

  localparam int CNT_W   = 4;
  localparam int STALL_W = 3;

  typedef struct packed {
    logic [4:0]         stb;
    logic [CNT_W-1:0]   ic;
    logic [STALL_W-1:0] sc;
    logic               err;
    logic               hlt;
  } exp_t;

  logic               CLK;
  logic               RST;
  logic [4:0]         Phases;
  logic               MemReady;
  logic               Halt;
  logic               IfEn, IdEn, ExEn, MemEn, WbEn;
  logic [CNT_W-1:0]   InstrCount;
  logic [STALL_W-1:0] StallCount;
  logic               PhaseErr;
  logic               Halted;

  phase_stage_sequencer #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .CLK(CLK), .RST(RST), .Phases(Phases), .MemReady(MemReady), .Halt(Halt),
    .IfEn(IfEn), .IdEn(IdEn), .ExEn(ExEn), .MemEn(MemEn), .WbEn(WbEn),
    .InstrCount(InstrCount), .StallCount(StallCount),
    .PhaseErr(PhaseErr), .Halted(Halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step_no    = 0;

  // Reference model state: 0 sync, 1 run, 2 memwait, 3 halted.
  int                 m_st  = 0;
  int                 m_stg = 0;
  bit                 m_pv  = 0;
  int                 m_pi  = 0;
  logic [CNT_W-1:0]   m_ic  = '0;
  logic [STALL_W-1:0] m_sc  = '0;
  logic               m_err = 1'b0;

  function automatic logic [4:0] ph_of(input int i);
    ph_of = 5'b00001 << i;
  endfunction

  task automatic model(input logic rst, input logic [4:0] ph, input logic mr, input logic h);
    exp_t e;
    int   idx;
    bit   ok;
    e.stb = '0;
    if (rst) begin
      m_st = 0; m_stg = 0; m_pv = 0; m_pi = 0;
      m_ic = '0; m_sc = '0; m_err = 1'b0;
    end else if (m_st != 3) begin
      idx = 0;
      for (int i = 0; i < 5; i++) if (ph[i]) idx = i;
      ok = ($countones(ph) == 1) && (!m_pv || idx == (m_pi + 1) % 5);
      if (!ok) begin
        m_err = 1'b1; m_st = 0; m_pv = 0;
      end else begin
        m_pv = 1; m_pi = idx;
        if (m_st == 0) begin
          if (idx == 0) begin e.stb[0] = 1'b1; m_stg = 1; m_st = 1; end
        end else if (m_st == 1) begin
          if (idx == m_stg) begin
            if (m_stg == 3 && !mr) begin
              if (m_sc != '1) m_sc = m_sc + 1'b1;
              m_st = 2;
            end else begin
              e.stb[m_stg] = 1'b1;
              if (m_stg == 4) begin
                m_ic = m_ic + 1'b1; m_stg = 0;
                if (h) m_st = 3;
              end else m_stg = m_stg + 1;
            end
          end
        end else if (m_st == 2 && idx == 3) begin
          if (mr) begin e.stb[3] = 1'b1; m_stg = 4; m_st = 1; end
          else if (m_sc != '1) m_sc = m_sc + 1'b1;
        end
      end
    end
    e.ic = m_ic; e.sc = m_sc; e.err = m_err; e.hlt = (m_st == 3);
    sb.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [4:0] ph, input logic mr, input logic h);
    exp_t exp_v, obs_v;
    RST = rst; Phases = ph; MemReady = mr; Halt = h;
    model(rst, ph, mr, h);
    @(negedge CLK);
    step_no++;
    exp_v = sb.pop_front();
    obs_v = '{stb: {WbEn, MemEn, ExEn, IdEn, IfEn}, ic: InstrCount, sc: StallCount,
              err: PhaseErr, hlt: Halted};
    compared++;
    assert (obs_v === exp_v) else begin
      mismatched++;
      $error("FAIL step%0d observed stb=%b ic=%0d sc=%0d err=%b hlt=%b expected stb=%b ic=%0d sc=%0d err=%b hlt=%b",
             step_no, obs_v.stb, obs_v.ic, obs_v.sc, obs_v.err, obs_v.hlt,
             exp_v.stb, exp_v.ic, exp_v.sc, exp_v.err, exp_v.hlt);
    end
  endtask

  task automatic rot(input int start, input int n, input logic mr);
    for (int k = 0; k < n; k++) step(1'b0, ph_of((start + k) % 5), mr, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    RST = 1'b1; Phases = 5'b00001; MemReady = 1'b1; Halt = 1'b0;

    // Reset, then a clean run of four instructions.
    step(1'b1, ph_of(0), 1'b1, 1'b0);
    step(1'b1, ph_of(0), 1'b1, 1'b0);
    check("reset_instr", InstrCount, 0);
    step(1'b0, ph_of(0), 1'b1, 1'b0);
    check("clean_first_if", IfEn, 1);
    rot(1, 19, 1'b1);
    check("clean_instr", InstrCount, 4);
    check("clean_stall", StallCount, 0);

    // Misaligned start: reset leaves the bus at phase 1, first live sample is phase 2.
    step(1'b1, ph_of(1), 1'b1, 1'b0);
    rot(2, 3, 1'b1);
    check("misalign_err", PhaseErr, 0);

    // One memory retry; MemReady outside an expected phase 3 is ignored.
    rot(0, 3, 1'b1);
    step(1'b0, ph_of(3), 1'b0, 1'b0);
    rot(4, 4, 1'b1);
    rot(3, 2, 1'b1);
    check("stall_count", StallCount, 1);
    check("stall_instr", InstrCount, 1);

    // Non one-hot injection mid-instruction, then resync.
    rot(0, 2, 1'b1);
    step(1'b0, 5'b00011, 1'b1, 1'b0);
    check("inject_err", PhaseErr, 1);
    rot(2, 3, 1'b1);
    rot(0, 5, 1'b1);
    check("inject_sticky", PhaseErr, 1);
    check("inject_instr", InstrCount, 2);

    // Skipped phase after reset.
    step(1'b1, ph_of(0), 1'b1, 1'b0);
    rot(0, 2, 1'b1);
    step(1'b0, ph_of(3), 1'b1, 1'b0);
    check("jump_err", PhaseErr, 1);
    rot(4, 1, 1'b1);
    rot(0, 5, 1'b1);
    check("jump_instr", InstrCount, 1);

    // Halt at WB of instruction 3; an earlier Halt outside WB is ignored.
    step(1'b1, ph_of(0), 1'b1, 1'b0);
    rot(0, 2, 1'b1);
    step(1'b0, ph_of(2), 1'b1, 1'b1);
    rot(3, 2, 1'b1);
    rot(0, 9, 1'b1);
    step(1'b0, ph_of(4), 1'b1, 1'b1);
    check("halt_flag", Halted, 1);
    check("halt_instr", InstrCount, 3);
    rot(0, 20, 1'b1);
    step(1'b1, ph_of(0), 1'b1, 1'b0);
    check("halt_cleared", {27'd0, Halted, InstrCount}, 0);

    // Retire counter wraps after 2^CNT_W instructions.
    rot(0, 80, 1'b1);
    check("instr_wrap", InstrCount, 0);
    rot(0, 5, 1'b1);
    check("instr_after_wrap", InstrCount, 1);

    // Stall counter saturates at all-ones.
    step(1'b1, ph_of(0), 1'b1, 1'b0);
    rot(0, 3, 1'b1);
    for (int r = 0; r < 10; r++) begin
      step(1'b0, ph_of(3), 1'b0, 1'b0);
      rot(4, 4, 1'b0);
    end
    check("stall_sat", StallCount, 7);
    rot(3, 2, 1'b1);
    check("sat_instr", InstrCount, 1);

    // Reset while waiting on memory, then restart.
    rot(0, 3, 1'b1);
    step(1'b0, ph_of(3), 1'b0, 1'b0);
    rot(4, 2, 1'b0);
    step(1'b1, ph_of(1), 1'b0, 1'b0);
    check("memwait_reset",
          {14'd0, WbEn, MemEn, ExEn, IdEn, IfEn, InstrCount, StallCount, PhaseErr, Halted}, 0);
    rot(2, 3, 1'b1);
    rot(0, 5, 1'b1);
    check("restart_instr", InstrCount, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
